// File: rtl/div_unit_if.sv
// Handshake bundle between the execute-stage control and the iterative divider.
// The master side issues requests; the slave side is the divider itself.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU,
// one quotient bit per clock, with single-cycle bypass for divide-by-zero and overflow.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  io_div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_work;
  logic [XLEN-1:0]  r_remainder;
  logic [XLEN-1:0]  r_absDivisor;
  logic             r_isRem;
  logic             r_negQuot;
  logic             r_negRem;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  logic             w_signed;
  logic [XLEN-1:0]  w_absDividend;
  logic [XLEN-1:0]  w_absDivisor;
  logic             w_divByZero;
  logic             w_overflow;
  logic [XLEN:0]    w_remShift;
  logic [XLEN:0]    w_remSub;
  logic             w_qBit;
  logic [XLEN-1:0]  w_remNext;
  logic [XLEN-1:0]  w_quotNext;
  logic [XLEN-1:0]  w_finalResult;

  assign w_signed      = ~io_div.op[0];
  assign w_absDividend = (w_signed && io_div.dividend[XLEN-1]) ? -io_div.dividend : io_div.dividend;
  assign w_absDivisor  = (w_signed && io_div.divisor[XLEN-1])  ? -io_div.divisor  : io_div.divisor;
  assign w_divByZero   = (io_div.divisor == '0);
  assign w_overflow    = w_signed && (io_div.dividend == MIN_NEG) && (io_div.divisor == '1);

  // The partial remainder is below 2^(k) after k steps, so the 33-bit view never wraps.
  assign w_remShift = {r_remainder, r_work[XLEN-1]};
  assign w_remSub   = w_remShift - {1'b0, r_absDivisor};
  assign w_qBit     = ~w_remSub[XLEN];
  assign w_remNext  = w_qBit ? w_remSub[XLEN-1:0] : w_remShift[XLEN-1:0];
  assign w_quotNext = {r_work[XLEN-2:0], w_qBit};

  assign w_finalResult = r_isRem ? (r_negRem  ? -w_remNext  : w_remNext)
                                 : (r_negQuot ? -w_quotNext : w_quotNext);

  // r_work shifts dividend bits out at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_work       <= '0;
      r_remainder  <= '0;
      r_absDivisor <= '0;
      r_isRem      <= 1'b0;
      r_negQuot    <= 1'b0;
      r_negRem     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
    end else if (io_div.flush) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (io_div.start) begin
            r_isRem      <= io_div.op[1];
            r_negQuot    <= w_signed && (io_div.dividend[XLEN-1] ^ io_div.divisor[XLEN-1]);
            r_negRem     <= w_signed && io_div.dividend[XLEN-1];
            r_absDivisor <= w_absDivisor;
            r_work       <= w_absDividend;
            r_remainder  <= '0;
            r_count      <= '0;
            r_busy       <= 1'b1;
            if (w_divByZero) begin
              r_result <= io_div.op[1] ? io_div.dividend : '1;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else if (w_overflow) begin
              r_result <= io_div.op[1] ? '0 : MIN_NEG;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_work      <= w_quotNext;
          r_remainder <= w_remNext;
          r_count     <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(XLEN-1)) begin
            r_result <= w_finalResult;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_div.busy   = r_busy;
  assign io_div.done   = r_done;
  assign io_div.result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table for the arithmetic and latency,
// plus hand sequences for start-while-busy, flush and asynchronous reset.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  div_unit_if #(.XLEN(32)) divIf ();

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_div (divIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a one-cycle start pulse; returns just after the sampling edge E0.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    divIf.start    = 1'b1;
    divIf.op       = op;
    divIf.dividend = a;
    divIf.divisor  = b;
    @(posedge clk);
    #1;
    divIf.start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen, bounded so a stuck DUT still ends.
  task automatic waitDone(input int startLat, output int lat, output int busyCnt);
    lat = startLat;
    busyCnt = 0;
    forever begin
      if (divIf.busy) busyCnt++;
      if (divIf.done || lat >= 100) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic watchNoDone(input int cycles, output int doneCnt);
    doneCnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (divIf.done) doneCnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   lat;
    int   busyCnt;
    int   doneCnt;

    vecs.push_back('{"divu 100/7",        OP_DIVU, 32'd100,      32'd7,        32'h0000000E, 32});
    vecs.push_back('{"remu 100/7",        OP_REMU, 32'd100,      32'd7,        32'h00000002, 32});
    vecs.push_back('{"div -7/2",          OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32});
    vecs.push_back('{"rem -7/2",          OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32});
    vecs.push_back('{"rem 7/-2",          OP_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32});
    vecs.push_back('{"div 7/-2",          OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32});
    vecs.push_back('{"div 5/0",           OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 0});
    vecs.push_back('{"remu 5/0",          OP_REMU, 32'd5,        32'd0,        32'h00000005, 0});
    vecs.push_back('{"divu 5/0",          OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
    vecs.push_back('{"rem 5/0",           OP_REM,  32'd5,        32'd0,        32'h00000005, 0});
    vecs.push_back('{"div ovf",           OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    vecs.push_back('{"rem ovf",           OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0});
    vecs.push_back('{"divu max/max",      OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32});
    vecs.push_back('{"remu fffe/ffff",    OP_REMU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32});
    vecs.push_back('{"divu 8000_0000/3",  OP_DIVU, 32'h80000000, 32'd3,        32'h2AAAAAAA, 32});
    vecs.push_back('{"div min/2",         OP_DIV,  32'h80000000, 32'd2,        32'hC0000000, 32});
    vecs.push_back('{"rem min/7",         OP_REM,  32'h80000000, 32'd7,        32'hFFFFFFFE, 32});
    vecs.push_back('{"divu 8000_0000/-1", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32});

    divIf.start    = 1'b0;
    divIf.flush    = 1'b0;
    divIf.op       = 2'b00;
    divIf.dividend = '0;
    divIf.divisor  = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy",   {31'b0, divIf.busy}, 32'd0);
    checkOutput("reset done",   {31'b0, divIf.done}, 32'd0);
    checkOutput("reset result", divIf.result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(0, lat, busyCnt);
      checkOutput({vecs[i].name, " done"},    {31'b0, divIf.done}, 32'd1);
      checkOutput({vecs[i].name, " result"},  divIf.result,        vecs[i].expRes);
      checkOutput({vecs[i].name, " latency"}, 32'(lat),            32'(vecs[i].expLat));
      checkOutput({vecs[i].name, " busy cycles"}, 32'(busyCnt),    32'(vecs[i].expLat + 1));
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, " idle after"}, {30'b0, divIf.busy, divIf.done}, 32'd0);
    end

    // Second start at cycle 5 of CALC must be ignored.
    applyStimulus(OP_DIVU, 32'd1000, 32'd10);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    divIf.start    = 1'b1;
    divIf.op       = OP_DIVU;
    divIf.dividend = 32'd50;
    divIf.divisor  = 32'd5;
    @(posedge clk);
    #1;
    divIf.start = 1'b0;
    checkOutput("busy during ignored start", {31'b0, divIf.busy}, 32'd1);
    waitDone(5, lat, busyCnt);
    checkOutput("ignored start result",  divIf.result, 32'd100);
    checkOutput("ignored start latency", 32'(lat),     32'd32);

    // Back-to-back: start sampled on the first IDLE edge after DONE.
    @(posedge clk);
    #1;
    applyStimulus(OP_DIVU, 32'd81, 32'd9);
    waitDone(0, lat, busyCnt);
    checkOutput("back-to-back result",  divIf.result, 32'd9);
    checkOutput("back-to-back latency", 32'(lat),     32'd32);
    @(posedge clk);
    #1;

    // Flush at CALC cycle 10.
    applyStimulus(OP_DIVU, 32'd12345, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    divIf.flush = 1'b1;
    @(posedge clk);
    #1;
    divIf.flush = 1'b0;
    checkOutput("flush busy", {31'b0, divIf.busy}, 32'd0);
    checkOutput("flush done", {31'b0, divIf.done}, 32'd0);
    watchNoDone(40, doneCnt);
    checkOutput("flush no done pulse", 32'(doneCnt), 32'd0);
    checkOutput("flush result held",   divIf.result, 32'd9);

    // Flush and start together in IDLE.
    @(negedge clk);
    divIf.start    = 1'b1;
    divIf.flush    = 1'b1;
    divIf.op       = OP_DIVU;
    divIf.dividend = 32'd20;
    divIf.divisor  = 32'd0;
    @(posedge clk);
    #1;
    divIf.start = 1'b0;
    divIf.flush = 1'b0;
    checkOutput("flush+start busy", {31'b0, divIf.busy}, 32'd0);
    watchNoDone(40, doneCnt);
    checkOutput("flush+start no done", 32'(doneCnt), 32'd0);
    checkOutput("flush+start result",  divIf.result, 32'd9);

    // Asynchronous reset in the middle of CALC.
    applyStimulus(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy",   {31'b0, divIf.busy}, 32'd0);
    checkOutput("async reset done",   {31'b0, divIf.done}, 32'd0);
    checkOutput("async reset result", divIf.result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_DIVU, 32'd9, 32'd3);
    waitDone(0, lat, busyCnt);
    checkOutput("post-reset result",  divIf.result, 32'd3);
    checkOutput("post-reset latency", 32'(lat),     32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
